// File: rtl/midi_tx_if.sv
// Request and byte-stream bundle between synth control, the MIDI encoder and the UART.
// Stream handshake: a byte moves on a clock-enabled edge where dv and ready are both high;
// while dv is high and ready is low, data is held unchanged.
interface midi_tx_if;
    logic [3:0] channel;
    logic       note_on_req;
    logic       note_off_req;
    logic       prog_req;
    logic [6:0] note_num;
    logic [6:0] note_vel;
    logic [6:0] program_num;
    logic       busy;
    logic [7:0] data;
    logic       dv;
    logic       ready;

    modport master (
        output channel, note_on_req, note_off_req, prog_req,
        output note_num, note_vel, program_num, ready,
        input  busy, data, dv
    );

    modport slave (
        input  channel, note_on_req, note_off_req, prog_req,
        input  note_num, note_vel, program_num, ready,
        output busy, data, dv
    );
endinterface

// File: rtl/midi_tx.sv
// MIDI transmit encoder: turns note-on/off and program-change requests into a
// status + data byte sequence on a valid/ready stream, with optional running status.
module midi_tx #(
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    midi_tx_if.slave         bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_STATUS = 2'd1,
        SEND_D1     = 2'd2,
        SEND_D2     = 2'd3
    } state_t;

    state_t     state_q, state_n;
    logic [7:0] status_q, status_n;
    logic [6:0] d1_q, d1_n;
    logic [6:0] d2_q, d2_n;
    logic       is_note_q, is_note_n;
    logic [7:0] last_q, last_n;
    logic [7:0] data_n;
    logic       dv_n;
    logic       busy_n;
    logic       any_req;
    logic       xfer;

    assign any_req   = bus.note_off_req | bus.note_on_req | bus.prog_req;
    assign xfer      = bus.dv & bus.ready;
    assign dbg_state = state_q;

    always_comb begin
        state_n   = state_q;
        status_n  = status_q;
        d1_n      = d1_q;
        d2_n      = d2_q;
        is_note_n = is_note_q;
        last_n    = last_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    // Note Off outranks Note On, which outranks Program Change.
                    if (bus.note_off_req) begin
                        status_n  = {4'h8, bus.channel};
                        is_note_n = 1'b1;
                        d1_n      = bus.note_num;
                    end else if (bus.note_on_req) begin
                        status_n  = {4'h9, bus.channel};
                        is_note_n = 1'b1;
                        d1_n      = bus.note_num;
                    end else begin
                        status_n  = {4'hC, bus.channel};
                        is_note_n = 1'b0;
                        d1_n      = bus.program_num;
                    end
                    d2_n = bus.note_vel;
                    if (RUNNING_STATUS && (status_n == last_q)) state_n = SEND_D1;
                    else                                        state_n = SEND_STATUS;
                end
            end
            SEND_STATUS: begin
                if (xfer) begin
                    last_n  = status_q;
                    state_n = SEND_D1;
                end
            end
            SEND_D1: begin
                if (xfer) state_n = is_note_q ? SEND_D2 : IDLE;
            end
            SEND_D2: begin
                if (xfer) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        dv_n   = 1'b1;
        data_n = 8'h00;
        unique case (state_n)
            IDLE:        dv_n   = 1'b0;
            SEND_STATUS: data_n = status_n;
            SEND_D1:     data_n = {1'b0, d1_n};
            SEND_D2:     data_n = {1'b0, d2_n};
            default:     dv_n   = 1'b0;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            status_q  <= 8'h00;
            d1_q      <= 7'h00;
            d2_q      <= 7'h00;
            is_note_q <= 1'b0;
            last_q    <= 8'h00;
            bus.data  <= 8'h00;
            bus.dv    <= 1'b0;
            bus.busy  <= 1'b0;
        end else if (ce) begin
            state_q   <= state_n;
            status_q  <= status_n;
            d1_q      <= d1_n;
            d2_q      <= d2_n;
            is_note_q <= is_note_n;
            last_q    <= last_n;
            bus.data  <= data_n;
            bus.dv    <= dv_n;
            bus.busy  <= busy_n;
        end
    end

endmodule
